// File: rtl/tlul_chk_pkg.sv
// tlul_chk_pkg -- shared types for the TL-UL transaction checker:
// error codes, checker FSM states, tracking-table entry and widths.
package tlul_chk_pkg;

  import tlul_pkg::*;

  localparam int unsigned AgeW     = 16;
  localparam int unsigned IntrCntW = 16;

  typedef enum logic [2:0] {
    ErrNone     = 3'd0,
    ErrOverflow = 3'd1,
    ErrDupSrc   = 3'd2,
    ErrUnexpRsp = 3'd3,
    ErrOpcode   = 3'd4,
    ErrTimeout  = 3'd5
  } err_code_e;

  typedef enum logic {
    StRun  = 1'b0,
    StFail = 1'b1
  } chk_state_e;

  typedef struct packed {
    logic              valid;
    logic [TL_AIW-1:0] source;
    logic              is_get;
    logic [AgeW-1:0]   age;
  } tbl_entry_t;

endpackage

// File: rtl/tlul_pkg.sv
// tlul_pkg -- minimal TL-UL channel types used by the checker.
// Only the fields the checker taps plus the usual payload fields are
// modelled; widths follow the common 32-bit TL-UL configuration.
package tlul_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned TL_DBW = TL_DW / 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_chk_table.sv
// tlul_chk_table -- in-flight request tracking table.
// Allocates entries on accepted requests, retires them on matching
// responses, ages them every cycle and raises per-cycle error flags.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_i/req_src_i/req_is_get_i  accepted request and its attributes
//   rsp_i/rsp_src_i/rsp_op_i      accepted response and its attributes
//   err_*_o              combinational per-cycle error flags
//   timeout_src_o        source of the lowest-index timed-out entry
//   outstanding_o        registered live entry count
module tlul_chk_table
  import tlul_pkg::*;
  import tlul_chk_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TimeoutCycles  = 1024,
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [TL_AIW-1:0] req_src_i,
  input  logic              req_is_get_i,
  input  logic              rsp_i,
  input  logic [TL_AIW-1:0] rsp_src_i,
  input  tl_d_op_e          rsp_op_i,
  output logic              err_overflow_o,
  output logic              err_dup_o,
  output logic              err_unexp_o,
  output logic              err_opcode_o,
  output logic              err_timeout_o,
  output logic [TL_AIW-1:0] timeout_src_o,
  output logic [OutW-1:0]   outstanding_o
);

  tbl_entry_t entry_q [MaxOutstanding];
  tbl_entry_t entry_d [MaxOutstanding];
  logic [OutW-1:0] out_q, out_d;

  logic [MaxOutstanding-1:0] valid_q, rsp_hit, req_hit, age_hit;
  logic [MaxOutstanding-1:0] retire, valid_post, alloc, timeout_hit;
  logic matched, matched_get, full, dup, found_free;

  for (genvar gi = 0; gi < MaxOutstanding; gi++) begin : g_cmp
    assign valid_q[gi] = entry_q[gi].valid;
    assign rsp_hit[gi] = entry_q[gi].valid && (entry_q[gi].source == rsp_src_i);
    assign req_hit[gi] = entry_q[gi].source == req_src_i;
    assign age_hit[gi] = entry_q[gi].age == AgeW'(TimeoutCycles - 1);
  end

  // Response lookup uses the start-of-cycle table; the duplicate and full
  // checks for a same-cycle request use the table after retirement.
  always_comb begin
    retire      = '0;
    matched     = 1'b0;
    matched_get = 1'b0;
    for (int i = 0; i < MaxOutstanding; i++) begin
      if (rsp_i && rsp_hit[i] && !matched) begin
        retire[i]   = 1'b1;
        matched     = 1'b1;
        matched_get = entry_q[i].is_get;
      end
    end
    valid_post = valid_q & ~retire;
    full       = &valid_post;
    dup        = |(valid_post & req_hit);

    alloc      = '0;
    found_free = 1'b0;
    for (int i = 0; i < MaxOutstanding; i++) begin
      if (req_i && !full && !dup && !valid_post[i] && !found_free) begin
        alloc[i]   = 1'b1;
        found_free = 1'b1;
      end
    end

    timeout_hit   = valid_post & age_hit;
    timeout_src_o = '0;
    for (int i = MaxOutstanding - 1; i >= 0; i--) begin
      if (timeout_hit[i]) timeout_src_o = entry_q[i].source;
    end
  end

  assign err_overflow_o = req_i && full;
  assign err_dup_o      = req_i && dup;
  assign err_unexp_o    = rsp_i && !matched;
  assign err_opcode_o   = matched && (matched_get ? (rsp_op_i != AccessAckData)
                                                  : (rsp_op_i != AccessAck));
  assign err_timeout_o  = |timeout_hit;

  always_comb begin
    out_d = '0;
    for (int i = 0; i < MaxOutstanding; i++) begin
      entry_d[i] = entry_q[i];
      if (retire[i]) begin
        entry_d[i] = '0;
      end else if (entry_q[i].valid && (entry_q[i].age != '1)) begin
        entry_d[i].age = entry_q[i].age + AgeW'(1);
      end
      if (alloc[i]) begin
        entry_d[i].valid  = 1'b1;
        entry_d[i].source = req_src_i;
        entry_d[i].is_get = req_is_get_i;
        entry_d[i].age    = '0;
      end
      out_d = out_d + OutW'(entry_d[i].valid);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxOutstanding; i++) entry_q[i] <= '0;
      out_q <= '0;
    end else begin
      for (int i = 0; i < MaxOutstanding; i++) entry_q[i] <= entry_d[i];
      out_q <= out_d;
    end
  end

  assign outstanding_o = out_q;

endmodule

// File: rtl/tlul_txn_checker.sv
// tlul_txn_checker -- passive TL-UL bus checker (drives nothing on the bus).
// Tracks in-flight requests, flags protocol errors/timeouts, latches the
// first error and counts requests, responses and interrupt rising edges.
// Optional feature macro: TLUL_CHK_INTR_CNT_EN enables the per-channel
// interrupt edge counters; without it intr_cnt_o is 0 and intr_i unused.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   tl_h2d_i        tapped host-to-device channel
//   tl_d2h_i        tapped device-to-host channel
//   intr_i          DUT interrupt lines
//   err_valid_o     sticky error flag
//   err_code_o      first error code
//   err_src_o       source ID tied to the first error
//   outstanding_o   live entry count
//   req_cnt_o, rsp_cnt_o  saturating handshake counters
//   intr_cnt_o      16-bit rising-edge count per interrupt channel
module tlul_txn_checker
  import tlul_pkg::*;
  import tlul_chk_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TimeoutCycles  = 1024,
  parameter int unsigned NumIntr        = 3,
  parameter int unsigned CntW           = 32,
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  tl_h2d_t                   tl_h2d_i,
  input  tl_d2h_t                   tl_d2h_i,
  input  logic [NumIntr-1:0]        intr_i,
  output logic                      err_valid_o,
  output err_code_e                 err_code_o,
  output logic [TL_AIW-1:0]         err_src_o,
  output logic [OutW-1:0]           outstanding_o,
  output logic [CntW-1:0]           req_cnt_o,
  output logic [CntW-1:0]           rsp_cnt_o,
  output logic [NumIntr*IntrCntW-1:0] intr_cnt_o
);

  logic a_acc, d_acc;
  assign a_acc = tl_h2d_i.a_valid && tl_d2h_i.a_ready;
  assign d_acc = tl_d2h_i.d_valid && tl_h2d_i.d_ready;

  logic unused_tl;
  assign unused_tl = ^{tl_h2d_i.a_param, tl_h2d_i.a_size, tl_h2d_i.a_address,
                       tl_h2d_i.a_mask, tl_h2d_i.a_data, tl_d2h_i.d_param,
                       tl_d2h_i.d_size, tl_d2h_i.d_sink, tl_d2h_i.d_data,
                       tl_d2h_i.d_error};

  logic err_ovf, err_dup, err_unexp, err_opc, err_tmo;
  logic [TL_AIW-1:0] tmo_src;

  tlul_chk_table #(
    .MaxOutstanding(MaxOutstanding),
    .TimeoutCycles (TimeoutCycles)
  ) u_table (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (a_acc),
    .req_src_i     (tl_h2d_i.a_source),
    .req_is_get_i  (tl_h2d_i.a_opcode == Get),
    .rsp_i         (d_acc),
    .rsp_src_i     (tl_d2h_i.d_source),
    .rsp_op_i      (tl_d2h_i.d_opcode),
    .err_overflow_o(err_ovf),
    .err_dup_o     (err_dup),
    .err_unexp_o   (err_unexp),
    .err_opcode_o  (err_opc),
    .err_timeout_o (err_tmo),
    .timeout_src_o (tmo_src),
    .outstanding_o (outstanding_o)
  );

  // Highest-priority error of this cycle
  logic              err_any;
  err_code_e         err_code_d;
  logic [TL_AIW-1:0] err_src_d;

  always_comb begin
    err_any    = 1'b1;
    err_code_d = ErrNone;
    err_src_d  = '0;
    if (err_ovf) begin
      err_code_d = ErrOverflow;
      err_src_d  = tl_h2d_i.a_source;
    end else if (err_dup) begin
      err_code_d = ErrDupSrc;
      err_src_d  = tl_h2d_i.a_source;
    end else if (err_unexp) begin
      err_code_d = ErrUnexpRsp;
      err_src_d  = tl_d2h_i.d_source;
    end else if (err_opc) begin
      err_code_d = ErrOpcode;
      err_src_d  = tl_d2h_i.d_source;
    end else if (err_tmo) begin
      err_code_d = ErrTimeout;
      err_src_d  = tmo_src;
    end else begin
      err_any = 1'b0;
    end
  end

  chk_state_e        state_q;
  logic              err_valid_q;
  err_code_e         err_code_q;
  logic [TL_AIW-1:0] err_src_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      err_valid_q <= 1'b0;
      err_code_q  <= ErrNone;
      err_src_q   <= '0;
    end else begin
      case (state_q)
        StRun: begin
          if (err_any) begin
            state_q     <= StFail;
            err_valid_q <= 1'b1;
            err_code_q  <= err_code_d;
            err_src_q   <= err_src_d;
          end
        end
        StFail: begin
          // first error held until reset
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_code_o  = err_code_q;
  assign err_src_o   = err_src_q;

  logic [CntW-1:0] req_cnt_q, rsp_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
    end else begin
      if (a_acc && (req_cnt_q != '1)) req_cnt_q <= req_cnt_q + CntW'(1);
      if (d_acc && (rsp_cnt_q != '1)) rsp_cnt_q <= rsp_cnt_q + CntW'(1);
    end
  end

  assign req_cnt_o = req_cnt_q;
  assign rsp_cnt_o = rsp_cnt_q;

`ifdef TLUL_CHK_INTR_CNT_EN
  logic [NumIntr-1:0] intr_prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) intr_prev_q <= '0;
    else         intr_prev_q <= intr_i;
  end

  for (genvar gi = 0; gi < NumIntr; gi++) begin : g_intr
    logic [IntrCntW-1:0] cnt_q;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (intr_i[gi] && !intr_prev_q[gi] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + IntrCntW'(1);
      end
    end
    assign intr_cnt_o[gi*IntrCntW +: IntrCntW] = cnt_q;
  end
`else
  logic unused_intr;
  assign unused_intr = ^intr_i;
  assign intr_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_tlul_txn_checker.sv
// tb_tlul_txn_checker -- directed self-checking bench for tlul_txn_checker.
// Expected values are queued as stimulus is driven and compared against
// the DUT outputs once they are due (one cycle after the handshake).
module tb_tlul_txn_checker;
  import tlul_pkg::*;
  import tlul_chk_pkg::*;

  localparam int unsigned MaxOut = 4;
  localparam int unsigned Tmo    = 16;
  localparam int unsigned NIntr  = 3;
  localparam int unsigned CntW   = 32;

  localparam int SelErrV = 0, SelCode = 1, SelSrc = 2, SelOut = 3,
                 SelReq = 4, SelRsp = 5, SelIntr = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  tl_h2d_t h2d;
  tl_d2h_t d2h;
  logic [NIntr-1:0] intr;
  logic err_valid;
  err_code_e err_code;
  logic [TL_AIW-1:0] err_src;
  logic [2:0] outstanding;
  logic [CntW-1:0] req_cnt, rsp_cnt;
  logic [NIntr*IntrCntW-1:0] intr_cnt;

  int errors = 0;
  int checks = 0;

  string       tag_q[$];
  int          sel_q[$];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  tlul_txn_checker #(
    .MaxOutstanding(MaxOut),
    .TimeoutCycles (Tmo),
    .NumIntr       (NIntr),
    .CntW          (CntW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tl_h2d_i     (h2d),
    .tl_d2h_i     (d2h),
    .intr_i       (intr),
    .err_valid_o  (err_valid),
    .err_code_o   (err_code),
    .err_src_o    (err_src),
    .outstanding_o(outstanding),
    .req_cnt_o    (req_cnt),
    .rsp_cnt_o    (rsp_cnt),
    .intr_cnt_o   (intr_cnt)
  );

  function automatic logic [63:0] observe(int sel);
    case (sel)
      SelErrV: return 64'(err_valid);
      SelCode: return 64'(err_code);
      SelSrc:  return 64'(err_src);
      SelOut:  return 64'(outstanding);
      SelReq:  return 64'(req_cnt);
      SelRsp:  return 64'(rsp_cnt);
      default: return 64'(intr_cnt);
    endcase
  endfunction

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [63:0] exp);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(exp);
  endtask

  task automatic drain();
    while (tag_q.size() > 0) begin
      string t;
      int s;
      logic [63:0] e;
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      compare(t, observe(s), e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    h2d.a_valid = 1'b0;
    d2h.d_valid = 1'b0;
  endtask

  task automatic set_req(input logic [7:0] src, input tl_a_op_e op);
    h2d.a_valid  = 1'b1;
    h2d.a_source = src;
    h2d.a_opcode = op;
  endtask

  task automatic set_rsp(input logic [7:0] src, input tl_d_op_e op);
    d2h.d_valid  = 1'b1;
    d2h.d_source = src;
    d2h.d_opcode = op;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic line(input string msg);
    $display("txn: %s | err_v=%0d code=%0d src=%0d out=%0d req=%0d rsp=%0d",
             msg, err_valid, err_code, err_src, outstanding, req_cnt, rsp_cnt);
  endtask

  initial begin
    int first_k;
    logic [63:0] intr_exp;
    h2d = '0;
    d2h = '0;
    h2d.d_ready = 1'b1;
    d2h.a_ready = 1'b1;
    intr = '0;
    tick();

    // Reset state
    do_reset();
    expect_val("rst_err_valid", SelErrV, 0);
    expect_val("rst_err_code", SelCode, 64'(ErrNone));
    expect_val("rst_err_src", SelSrc, 0);
    expect_val("rst_outstanding", SelOut, 0);
    expect_val("rst_req_cnt", SelReq, 0);
    expect_val("rst_rsp_cnt", SelRsp, 0);
    expect_val("rst_intr_cnt", SelIntr, 0);
    drain();
    line("reset");

    // Get src=3, AccessAckData after 5 cycles
    set_req(3, Get);
    tick();
    idle();
    expect_val("get3_out", SelOut, 1);
    expect_val("get3_req", SelReq, 1);
    drain();
    line("Get src=3");
    repeat (4) tick();
    set_rsp(3, AccessAckData);
    tick();
    idle();
    expect_val("ack3_out", SelOut, 0);
    expect_val("ack3_rsp", SelRsp, 1);
    expect_val("ack3_req", SelReq, 1);
    expect_val("ack3_errv", SelErrV, 0);
    drain();
    line("AccessAckData src=3");

    // Overflow: four Puts then a fifth request
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(8'(i), PutFullData);
      tick();
    end
    idle();
    expect_val("fill_out", SelOut, 4);
    expect_val("fill_errv", SelErrV, 0);
    drain();
    line("Put src=0..3");
    set_req(4, Get);
    tick();
    idle();
    expect_val("ovf_errv", SelErrV, 1);
    expect_val("ovf_code", SelCode, 64'(ErrOverflow));
    expect_val("ovf_src", SelSrc, 4);
    expect_val("ovf_out", SelOut, 4);
    expect_val("ovf_req", SelReq, 5);
    drain();
    line("Get src=4 overflow");

    // Unexpected response, then first error held
    do_reset();
    set_rsp(7, AccessAck);
    tick();
    idle();
    expect_val("unexp_code", SelCode, 64'(ErrUnexpRsp));
    expect_val("unexp_src", SelSrc, 7);
    expect_val("unexp_rsp", SelRsp, 1);
    drain();
    line("AccessAck src=7 unexpected");
    set_req(7, Get);
    tick();
    idle();
    expect_val("held_code", SelCode, 64'(ErrUnexpRsp));
    expect_val("held_out", SelOut, 1);
    drain();
    line("Get src=7 after error");

    // Opcode mismatch: Get answered with AccessAck
    do_reset();
    set_req(2, Get);
    tick();
    idle();
    tick();
    set_rsp(2, AccessAck);
    tick();
    idle();
    expect_val("opc_code", SelCode, 64'(ErrOpcode));
    expect_val("opc_src", SelSrc, 2);
    expect_val("opc_out", SelOut, 0);
    drain();
    line("Get src=2 / AccessAck");

    // Timeout: Put src=1 with no response
    do_reset();
    set_req(1, PutFullData);
    tick();
    idle();
    first_k = -1;
    for (int k = 1; k <= 24 && first_k < 0; k++) begin
      tick();
      if (err_valid === 1'b1) first_k = k;
    end
    compare("tmo_cycles", 64'(first_k), 64'd16);
    expect_val("tmo_code", SelCode, 64'(ErrTimeout));
    expect_val("tmo_src", SelSrc, 1);
    expect_val("tmo_out", SelOut, 1);
    drain();
    line("Put src=1 timeout");

    // Priority: duplicate request beats unexpected response in same cycle
    do_reset();
    set_req(1, Get);
    tick();
    set_req(1, Get);
    set_rsp(9, AccessAck);
    tick();
    idle();
    expect_val("prio_code", SelCode, 64'(ErrDupSrc));
    expect_val("prio_src", SelSrc, 1);
    drain();
    line("dup src=1 + unexp src=9");

    // Same-cycle retire and re-request of the same source
    do_reset();
    set_req(5, Get);
    tick();
    set_req(5, Get);
    set_rsp(5, AccessAckData);
    tick();
    idle();
    expect_val("same_errv", SelErrV, 0);
    expect_val("same_out", SelOut, 1);
    expect_val("same_req", SelReq, 2);
    expect_val("same_rsp", SelRsp, 1);
    drain();
    line("rsp src=5 + Get src=5");
    for (int i = 8; i < 11; i++) begin
      set_req(8'(i), PutPartialData);
      tick();
    end
    set_req(11, Get);
    set_rsp(8, AccessAck);
    tick();
    idle();
    expect_val("full_retire_errv", SelErrV, 0);
    expect_val("full_retire_out", SelOut, 4);
    drain();
    line("full table rsp src=8 + Get src=11");

    // Reset mid-flight
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_val("mid_rst_errv", SelErrV, 0);
    expect_val("mid_rst_out", SelOut, 0);
    expect_val("mid_rst_req", SelReq, 0);
    expect_val("mid_rst_rsp", SelRsp, 0);
    drain();
    line("reset mid-flight");
    set_rsp(5, AccessAckData);
    tick();
    idle();
    expect_val("post_rst_code", SelCode, 64'(ErrUnexpRsp));
    expect_val("post_rst_src", SelSrc, 5);
    drain();
    line("rsp src=5 after reset");

    // Interrupt edge counting
    do_reset();
    for (int p = 0; p < 3; p++) begin
      intr = 3'b010;
      tick();
      intr = 3'b000;
      tick();
    end
    intr = 3'b001;
    repeat (3) tick();
    intr = 3'b000;
    tick();
`ifdef TLUL_CHK_INTR_CNT_EN
    intr_exp = {16'd0, 16'd0, 16'd3, 16'd1};
`else
    intr_exp = 64'd0;
`endif
    expect_val("intr_cnt", SelIntr, intr_exp);
    drain();
    $display("txn: intr pulses | intr_cnt=%0h", intr_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlul_txn_checker.md
Name: tlul_txn_checker

Overview:
- Passive, parametrised TL-UL bus checker for the fuzzing harness wrappers; instantiated beside the DUT and tapping both TL-UL directions.
- Tracks up to MaxOutstanding in-flight requests by source ID and matches each response to its request.
- Flags protocol violations and timeouts, latches the first error, and counts requests, responses and interrupt edges so the fuzzer gets coverage and crash signals.
- Drives nothing on the bus.

Parameters:
- MaxOutstanding, 4, tracking-table entries (1..16).
- TimeoutCycles, 1024, cycles an entry may wait for its response before a timeout error (>=2).
- NumIntr, 3, number of interrupt inputs observed.
- CntW, 32, width of the request/response counters.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  synchronous active-low reset.
- tl_h2d_i  input  tlul_pkg::tl_h2d_t  host-to-device channel (tapped).
- tl_d2h_i  input  tlul_pkg::tl_d2h_t  device-to-host channel (tapped).
- intr_i  input  NumIntr  DUT interrupt lines.
- err_valid_o  output  1  sticky: an error has been seen.
- err_code_o  output  tlul_chk_pkg::err_code_e  first error code.
- err_src_o  output  TL_AIW  source ID tied to the first error.
- outstanding_o  output  $clog2(MaxOutstanding+1)  live entry count.
- req_cnt_o  output  CntW  accepted requests.
- rsp_cnt_o  output  CntW  accepted responses.
- intr_cnt_o  output  NumIntr*16  per-channel rising-edge counts.

Behaviour:
- Clock and reset: single clock clk_i; reset is synchronous and active-low on rst_ni. While rst_ni=0 at a clk_i edge, all outputs, counters and table entries clear to 0, and err_code_o=ErrNone.
- Reset mid-operation drops all outstanding entries. Responses to those entries that arrive after reset are reported as ErrUnexpRsp.
- Handshakes:
  - A request is accepted when a_valid && a_ready; a response when d_valid && d_ready.
  - Counters saturate at all-ones.
  - Outputs are registered: one cycle of latency from handshake to outputs.
- Table entry fields: valid, source, is_get (Get opcode), 16-bit age.
- Request accept:
  - Allocates the lowest-index free entry.
  - Table full -> ErrOverflow; no allocation.
  - a_source already valid in the table -> ErrDupSrc; no allocation.
- Response accept:
  - Looks up d_source in the table as it stood at the start of the cycle; a request accepted in the same cycle is not visible.
  - No match -> ErrUnexpRsp.
  - Match with wrong opcode (Get expects AccessAckData; PutFull/PutPartial expect AccessAck) -> ErrOpcode. The entry is still retired.
  - d_error is not an error.
- Same cycle, response retires entry k and a request arrives with the same source:
  - The duplicate check uses the post-retire table, so the request allocates and no error is raised.
  - The full check also uses post-retire occupancy.
- Age and timeout:
  - Each valid entry's age increments every cycle and saturates.
  - Age reaching TimeoutCycles-1 -> ErrTimeout; the entry remains valid.
- Error FSM, two states:
  - RUN -> FAIL on any error; the code and source are latched.
  - If several errors occur in one cycle, priority is ErrOverflow > ErrDupSrc > ErrUnexpRsp > ErrOpcode > ErrTimeout.
  - FAIL is held until reset. Tracking and counting continue in FAIL.
- Interrupt counting:
  - Rising edge detected against the registered previous value; the previous-value register resets to 0.
  - 16-bit saturating count per channel.

Optional Feature:
- Macro: TLUL_CHK_INTR_CNT_EN.
- Defined: interrupt edge counters are implemented as described.
- Undefined: no counter flops; intr_cnt_o is tied to 0, and intr_i is ignored (waived unused).
- The table and error logic are unaffected either way.

Decomposition:
- tlul_chk_pkg holds:
  - err_code_e (ErrNone=0, ErrOverflow=1, ErrDupSrc=2, ErrUnexpRsp=3, ErrOpcode=4, ErrTimeout=5).
  - The entry struct type.
  - The AgeW=16 and IntrCntW=16 constants.
- One sub-module, tlul_chk_table, holds the entries, allocation, lookup and retirement and outputs the per-cycle error flags. The top level keeps the error FSM and the counters.

Test Plan:
- Reset, then Get src=3 followed by AccessAckData src=3 after 5 cycles -> req_cnt_o=1, rsp_cnt_o=1, outstanding_o back to 0, err_valid_o=0.
- Four Puts (src 0..3) with no responses, then a fifth request -> err_code_o=ErrOverflow, err_src_o=4, outstanding_o=4.
- AccessAck src=7 with nothing outstanding -> ErrUnexpRsp, err_src_o=7; a later Get src=7 does not change err_code_o.
- Get src=2 answered with AccessAck -> ErrOpcode, outstanding_o=0. Separately, with TimeoutCycles=16, Put src=1 with no response -> ErrTimeout asserted 16 cycles after the accept (±1 for output registration).
- Same cycle: response src=5 retires entry and new Get src=5 is accepted -> no error, outstanding_o unchanged. Then rst_ni low for one edge mid-flight -> all outputs 0.
- With TLUL_CHK_INTR_CNT_EN: pulse intr_i[1] three times -> intr_cnt_o for channel 1 = 3, others 0. Without the macro -> intr_cnt_o=0.
